// File: rtl/upc_sequencer_if.sv
// upc_sequencer_if: decoder <-> program sequencer bundle.
//   master : decoder side; drives en/op/zero/offset (and irq), observes pc/status.
//   slave  : sequencer side; consumes the decode fields, drives pc/stack_level/flags.
// Optional interrupt signals (irq, irq_ack) exist only when UPC_SEQ_IRQ_EN is defined.
interface upc_sequencer_if #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SL_W = $clog2(STACK_DEPTH + 1);

  logic            en;
  logic [2:0]      op;
  logic            zero;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] pc;
  logic [SL_W-1:0] stack_level;
  logic            overflow;
  logic            underflow;
  logic            halted;
`ifdef UPC_SEQ_IRQ_EN
  logic            irq;
  logic            irq_ack;

  modport master (output en, op, zero, offset, irq,
                  input  pc, stack_level, overflow, underflow, halted, irq_ack);
  modport slave  (input  en, op, zero, offset, irq,
                  output pc, stack_level, overflow, underflow, halted, irq_ack);
`else
  modport master (output en, op, zero, offset,
                  input  pc, stack_level, overflow, underflow, halted);
  modport slave  (input  en, op, zero, offset,
                  output pc, stack_level, overflow, underflow, halted);
`endif
endinterface

// File: rtl/upc_sequencer.sv
// upc_sequencer: uPC program sequencer (PC register, return stack, branch
// adder, PC-source select, sticky stack faults and halt).
// Ports:
//   CLK    - system clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - upc_sequencer_if.slave: en/op/zero/offset in; pc/stack_level/
//            overflow/underflow/halted out (irq/irq_ack with UPC_SEQ_IRQ_EN)
// Build option: define UPC_SEQ_IRQ_EN to add the level interrupt with an
// internal enable bit; without it op 7 (RETI) behaves as RET.
module upc_sequencer #(
  parameter int              PC_W        = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [PC_W-1:0] IRQ_VEC     = PC_W'('hF0)
) (
  input  logic           CLK,
  input  logic           reset,
  upc_sequencer_if.slave bus
);
  localparam int SL_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SL_W-1:0] FULL_LVL = SL_W'(STACK_DEPTH);

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JMP  = 3'd1, OP_JZ   = 3'd2,
                         OP_CALL = 3'd3, OP_RET  = 3'd4, OP_JABS = 3'd5,
                         OP_HALT = 3'd6, OP_RETI = 3'd7;

  // Two halt flavours: only a software HALT may be woken by an interrupt.
  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;
  state_t state, state_nxt;

  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, pc_rel, top, push_val;
  logic [SL_W-1:0] sp_q, sp_nxt;
  logic [PC_W-1:0] stk [STACK_DEPTH];
  logic            ovf_q, ovf_nxt, unf_q, unf_nxt;
  logic            push, full, empty, run, go_halt, go_fault, take;

  assign full   = (sp_q == FULL_LVL);
  assign empty  = (sp_q == '0);
  assign run    = bus.en && (state == S_RUN);
  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + bus.offset;       // no +1: uPC branch convention
  assign top    = stk[IDX_W'(sp_q - 1'b1)];

`ifdef UPC_SEQ_IRQ_EN
  logic ie_q, ack_q;
  assign take = bus.en && bus.irq && ie_q && !full &&
                (state == S_RUN || state == S_HALT);

  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      ie_q  <= 1'b1;
      ack_q <= 1'b0;
    end else begin
      ack_q <= take;
      if (take)                                    ie_q <= 1'b0;
      else if (run && bus.op == OP_RETI && !empty) ie_q <= 1'b1;
    end

  assign bus.irq_ack = ack_q;
`else
  assign take = 1'b0;
`endif

  // Datapath next-state: PC source select and stack push/pop.
  always_comb begin
    pc_nxt   = pc_q;
    sp_nxt   = sp_q;
    push     = 1'b0;
    push_val = pc_inc;
    ovf_nxt  = ovf_q;
    unf_nxt  = unf_q;
    go_halt  = 1'b0;
    go_fault = 1'b0;
    if (take) begin
      // interrupted op is discarded and re-executes on return
      push     = 1'b1;
      push_val = pc_q;
      sp_nxt   = sp_q + 1'b1;
      pc_nxt   = IRQ_VEC;
    end else if (run) begin
      case (bus.op)
        OP_NEXT: pc_nxt = pc_inc;
        OP_JMP:  pc_nxt = pc_rel;
        OP_JZ:   pc_nxt = bus.zero ? pc_rel : pc_inc;
        OP_CALL:
          if (full) begin
            ovf_nxt  = 1'b1;
            go_fault = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = sp_q + 1'b1;
            pc_nxt = pc_rel;
          end
        OP_RET, OP_RETI:
          if (empty) begin
            unf_nxt  = 1'b1;
            go_fault = 1'b1;
          end else begin
            sp_nxt = sp_q - 1'b1;
            pc_nxt = top;
          end
        OP_JABS: pc_nxt = bus.offset;
        OP_HALT: go_halt = 1'b1;
        default: ;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge CLK or posedge reset)
    if (reset) state <= S_RUN;
    else       state <= state_nxt;

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (take)          state_nxt = S_RUN;
    else if (go_fault) state_nxt = S_FAULT;
    else if (go_halt)  state_nxt = S_HALT;
  end

  // FSM: outputs
  always_comb begin
    bus.halted = (state != S_RUN);
  end

  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      pc_q  <= RESET_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      sp_q  <= sp_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end

  // Stack contents need no reset; the pointer alone defines validity.
  always_ff @(posedge CLK)
    if (push) stk[IDX_W'(sp_q)] <= push_val;

  assign bus.pc          = pc_q;
  assign bus.stack_level = sp_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
endmodule

// File: doc/upc_sequencer.md
Name: upc_sequencer

Overview:
Parametrised program sequencer for the uPC core. It replaces the fixed 8-bit PC counter, return stack, branch adder and PC-source mux with one block that generalises PC width and stack depth. It adds sticky stack-fault detection and a halt state. It sits between the decoder, which supplies `op` and the offset, and the instruction ROM, which is addressed by `pc`.

Parameters:
PC_W, 8, width of PC, offset and stack entries
STACK_DEPTH, 4, number of return-address entries (>=1)
RESET_PC, 0, PC value loaded on reset
IRQ_VEC, 8'hF0 (PC_W bits), interrupt entry address (used only with UPC_SEQ_IRQ_EN)

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
en  in  1  advance enable; when low all state holds
op  in  3  0 NEXT, 1 JMP rel, 2 JZ rel, 3 CALL rel, 4 RET, 5 JABS, 6 HALT, 7 RETI
zero  in  1  ALU zero flag for JZ
offset  in  PC_W  signed relative offset, or absolute target for JABS
pc  out  PC_W  current instruction address
stack_level  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries
overflow  out  1  sticky; CALL attempted while stack full
underflow  out  1  sticky; RET/RETI attempted while stack empty
halted  out  1  sequencer stopped
irq  in  1  level interrupt request (only with UPC_SEQ_IRQ_EN)
irq_ack  out  1  one-cycle pulse when interrupt taken (only with UPC_SEQ_IRQ_EN)

Behaviour:
- Reset (async, any time, including mid-CALL): pc=RESET_PC, stack_level=0, overflow=0, underflow=0, halted=0, irq_ack=0, ie=1. Stack contents are don't-care.
- All updates occur on the rising CLK edge when en=1 and halted=0. Otherwise all registers hold and irq_ack=0.
- All PC arithmetic is modulo 2^PC_W; wrap is silent.
  - "rel" means pc + offset. There is no +1; this is the existing uPC branch convention.
  - Example: pc=8'hFF, NEXT -> 8'h00.
- NEXT: pc <= pc+1.
- JMP: pc <= pc+offset.
- JZ: if zero=1, pc <= pc+offset; else pc <= pc+1.
- JABS: pc <= offset.
- CALL, stack not full: push pc+1, stack_level+1, pc <= pc+offset.
- CALL, stack full: no push, overflow <= 1, halted <= 1, pc holds.
- RET, stack not empty: pc <= top entry, stack_level-1.
- RET, stack empty: underflow <= 1, halted <= 1, pc holds.
- HALT: halted <= 1, pc holds.
- Halt exits only via reset, except as stated under the optional feature.
- Stack is LIFO with a single registered pointer. No combinational path from `op` to `pc`; `pc` is a register output.
- 1-cycle latency: the PC for the next instruction is visible the cycle after the op is presented.

Optional Feature:
- Macro: UPC_SEQ_IRQ_EN.
- With the macro defined:
  - Ports `irq`/`irq_ack` exist, plus an internal `ie` bit (1 after reset).
  - Interrupt taken when en=1, irq=1, ie=1 and the stack is not full. It has priority over `op`, and `op` is discarded.
  - Taking an interrupt: push the current pc (the discarded instruction re-executes on return), pc <= IRQ_VEC, ie <= 0, irq_ack=1 for one cycle.
  - Stack full: the interrupt is not taken, stays pending and sets no flag.
  - An interrupt is also taken while halted, but only from a HALT op. Fault halts (overflow/underflow) ignore irq. Taking it clears halted.
  - RETI: as RET, and also sets ie <= 1.
- Without the macro: no `irq`/`irq_ack` ports, no `ie`, and op 7 behaves exactly as RET.

Test Plan:
- Reset, then 3x NEXT with en=1 -> pc 0,1,2,3. Drop en for 2 cycles -> pc stays 3. Assert reset mid-cycle -> pc=0 immediately.
- pc=8'h10, JZ offset=8'hFC: zero=0 -> pc=8'h11; then zero=1 -> pc=8'h0D. From pc=8'hFE, JMP offset=8'h05 -> pc=8'h03.
- Nested CALLs from pc=8'h00,+4 then +4: pc 8'h04, 8'h08, stack_level=2. RET, RET -> pc=8'h05, then 8'h01, stack_level=0.
- 4 CALLs fill the stack (STACK_DEPTH=4); the 5th CALL -> overflow=1, halted=1, pc unchanged. Further ops are ignored until reset.
- RET at stack_level=0 -> underflow=1, halted=1. HALT op -> halted=1, flags 0, pc holds.
- UPC_SEQ_IRQ_EN:
  - At pc=8'h20, irq=1 -> pc=8'hF0, irq_ack pulse, stack_level=1. A second irq is ignored (ie=0).
  - RETI -> pc=8'h20, ie=1.
  - HALT then irq -> wakes to 8'hF0.
